anb_wr_tlp_framer_m: RTL and testbench

//  Downstream neighbour of the ANB write splitter. Turns each page-bounded write segment into one PCIe Memory Write TLP:
//  - takes one segment descriptor (addr, byte len) plus its DW-packed data beats;
//  - builds the 3DW header (addr < 4 GB) or the 4DW header, with DW count, first BE and last BE;
//  - merges header and payload into one sop/eop beat stream for the PCIe core adapter.

---
 rtl/anb_wr_tlp_framer_m_if.sv | 23 ++
 rtl/anb_wr_tlp_framer_m.sv | 201 ++++++++++++++++++++
 tb/tb_anb_wr_tlp_framer_m.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/anb_wr_tlp_framer_m_if.sv
// ANB address and data channels feeding the write TLP framer.
// The m modport drives a channel and the s modport receives it.
`timescale 1ns/1ps

interface anb_addr_channel_if;
  logic        avalid;
  logic        aready;
  logic [63:0] addr;
  logic [12:0] len;

  modport m (output avalid, addr, len, input aready);
  modport s (input avalid, addr, len, output aready);
endinterface

interface anb_data_channel_if;
  logic         valid;
  logic         ready;
  logic [127:0] data;
  logic         last;

  modport m (output valid, data, last, input ready);
  modport s (input valid, data, last, output ready);
endinterface

// File: rtl/anb_wr_tlp_framer_m.sv
// Frames one page-bounded ANB write segment into a PCIe Memory Write TLP.
// The output is a registered sop/eop beat stream. In 3DW mode the payload is shifted by one DW.
`timescale 1ns/1ps

module anb_wr_tlp_framer_m #(
  parameter type         ADDR_T = logic [63:0],
  parameter type         LEN_T  = logic [12:0],
  parameter type         DATA_T = logic [127:0],
  parameter logic [15:0] REQ_ID = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  anb_addr_channel_if.s m_a,
  anb_data_channel_if.s m_d,
  output logic          tlp_valid,
  input  logic          tlp_ready,
  output DATA_T         tlp_data,
  output logic          tlp_sop,
  output logic          tlp_eop,
  output logic [3:0]    tlp_keep,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, FLUSH} state_e;

  state_e      state, state_nxt;
  ADDR_T       d_addr;
  LEN_T        d_len;
  logic [8:0]  in_cnt;
  logic [95:0] carry;
  logic        err_seen;

  // Header fields derived from the registered descriptor
  logic [1:0]  a_lo;
  logic [12:0] byte_end;
  logic [10:0] dwc;
  logic [8:0]  in_beats;
  logic [1:0]  e;
  logic [3:0]  fbe, lbe, fbe_raw, lbe_raw;
  logic        is_4dw, need_flush, last_in, can_load;
  logic [3:0]  eop_keep;
  logic [31:0] hdr_dw0, hdr_dw1, hdr_addr_lo;

  always_comb begin
    a_lo        = d_addr[1:0];
    byte_end    = {11'b0, a_lo} + d_len;
    dwc         = 11'((byte_end + 13'd3) >> 2);
    in_beats    = 9'((dwc + 11'd3) >> 2);
    e           = 2'(byte_end - 13'd1);
    fbe_raw     = 4'hF << a_lo;
    lbe_raw     = 4'hF >> (2'd3 - e);
    fbe         = (dwc == 11'd1) ? (fbe_raw & lbe_raw) : fbe_raw;
    lbe         = (dwc == 11'd1) ? 4'h0 : lbe_raw;
    is_4dw      = |d_addr[63:32];
    need_flush  = !is_4dw && (dwc[1:0] != 2'd1);
    last_in     = (in_cnt == in_beats - 9'd1);
    can_load    = !tlp_valid || tlp_ready;
    hdr_dw0     = {(is_4dw ? 3'b011 : 3'b010), 5'b0, 14'b0, dwc[9:0]};
    hdr_dw1     = {REQ_ID, 8'h00, lbe, fbe};
    hdr_addr_lo = {d_addr[31:2], 2'b00};
    // In 3DW mode the three header DWs shift the payload, so the eop fill follows dwc+3.
    unique case (is_4dw ? dwc[1:0] : dwc[1:0] + 2'd3)
      2'd0:    eop_keep = 4'b1111;
      2'd1:    eop_keep = 4'b0001;
      2'd2:    eop_keep = 4'b0011;
      default: eop_keep = 4'b0111;
    endcase
  end

  logic        aready_c, d_ready_c, load, take_desc, take_beat, err_nxt;
  logic        ld_sop, ld_eop;
  logic [3:0]  ld_keep;
  DATA_T       ld_data;

  // NOTE: every signal gets a default before the case. A path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    aready_c  = 1'b0;
    d_ready_c = 1'b0;
    load      = 1'b0;
    ld_data   = '0;
    ld_sop    = 1'b0;
    ld_eop    = 1'b0;
    ld_keep   = 4'hF;
    take_desc = 1'b0;
    take_beat = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        aready_c = 1'b1;
        if (m_a.avalid) begin
          if (m_a.len == '0) begin
            err_nxt = 1'b1;
          end else begin
            take_desc = 1'b1;
            state_nxt = HDR;
          end
        end
      end
      HDR: begin
        if (is_4dw) begin
          if (can_load) begin
            load      = 1'b1;
            ld_sop    = 1'b1;
            ld_data   = {hdr_addr_lo, d_addr[63:32], hdr_dw1, hdr_dw0};
            state_nxt = DATA;
          end
        end else begin
          d_ready_c = can_load;
          if (m_d.valid && can_load) begin
            take_beat = 1'b1;
            load      = 1'b1;
            ld_sop    = 1'b1;
            ld_data   = {m_d.data[31:0], hdr_addr_lo, hdr_dw1, hdr_dw0};
            state_nxt = DATA;
            if (last_in) begin
              if (need_flush) begin
                state_nxt = FLUSH;
              end else begin
                ld_eop    = 1'b1;
                ld_keep   = eop_keep;
                state_nxt = IDLE;
              end
            end
          end
        end
      end
      DATA: begin
        d_ready_c = can_load;
        if (m_d.valid && can_load) begin
          take_beat = 1'b1;
          load      = 1'b1;
          ld_data   = is_4dw ? m_d.data : {m_d.data[31:0], carry};
          if (last_in) begin
            if (need_flush) begin
              state_nxt = FLUSH;
            end else begin
              ld_eop    = 1'b1;
              ld_keep   = eop_keep;
              state_nxt = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        if (can_load) begin
          load      = 1'b1;
          ld_data   = {32'h0, carry};
          ld_eop    = 1'b1;
          ld_keep   = eop_keep;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Report only one last-mismatch per TLP. Framing always follows the computed beat count.
    if (take_beat && (m_d.last != last_in) && !err_seen) err_nxt = 1'b1;
  end

  assign m_a.aready = aready_c & rst;
  assign m_d.ready  = d_ready_c & rst;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tlp_valid <= 1'b0;
      err       <= 1'b0;
      err_seen  <= 1'b0;
      in_cnt    <= '0;
    end else begin
      state <= state_nxt;
      err   <= err_nxt;
      if (take_desc) begin
        in_cnt   <= '0;
        err_seen <= 1'b0;
      end else if (take_beat) begin
        in_cnt <= in_cnt + 9'd1;
        if (err_nxt) err_seen <= 1'b1;
      end
      if (load)           tlp_valid <= 1'b1;
      else if (tlp_ready) tlp_valid <= 1'b0;
    end
  end

  // NOTE: datapath registers have no reset. Their contents are only used while the matching valid or state is set.
  always_ff @(posedge clk) begin
    if (take_desc) begin
      d_addr <= m_a.addr;
      d_len  <= m_a.len;
    end
    if (take_beat) carry <= m_d.data[127:32];
    if (load) begin
      tlp_data <= ld_data;
      tlp_sop  <= ld_sop;
      tlp_eop  <= ld_eop;
      tlp_keep <= ld_keep;
    end
  end

endmodule

// File: tb/tb_anb_wr_tlp_framer_m.sv
// Directed bench for anb_wr_tlp_framer_m. A table of hand-computed TLP headers is compared beat by beat
// against the concatenated header+payload DW stream. Hand-written sequences cover the error and reset cases.
`timescale 1ns/1ps

module tb_anb_wr_tlp_framer_m;

  logic         clk = 1'b0;
  logic         rst;
  logic         tlp_valid, tlp_ready, tlp_sop, tlp_eop, err;
  logic [127:0] tlp_data;
  logic [3:0]   tlp_keep;

  anb_addr_channel_if a_if ();
  anb_data_channel_if d_if ();

  anb_wr_tlp_framer_m dut (
    .clk       (clk),
    .rst       (rst),
    .m_a       (a_if),
    .m_d       (d_if),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .tlp_data  (tlp_data),
    .tlp_sop   (tlp_sop),
    .tlp_eop   (tlp_eop),
    .tlp_keep  (tlp_keep),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      addr;
    logic [12:0]      len;
    int               hdr_n;
    logic [3:0][31:0] hdr;       // {DW3, DW2, DW1, DW0}
    int               out_beats;
    int               in_beats;
    logic [3:0]       eop_keep;
  } vec_t;

  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   err_pulses = 0;

  always @(negedge clk) if (err === 1'b1) err_pulses++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pay(input int tag, input int p);
    return {tag[15:0], p[15:0]};
  endfunction

  function automatic logic [31:0] exp_dw(input vec_t v, input int tag, input int k);
    if (k < v.hdr_n) return v.hdr[k];
    return pay(tag, k - v.hdr_n);
  endfunction

  task automatic drive_tlp(input vec_t v, input int tag, input bit rnd, input bit early);
    bit ok = 1'b0;
    int i = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      a_if.avalid = 1'b1;
      a_if.addr   = v.addr;
      a_if.len    = v.len;
      #2;
      if (a_if.aready) begin ok = 1'b1; break; end
    end
    check("desc_accept", ok, 1'b1);
    for (int c = 0; c < 6000 && i < v.in_beats; c++) begin
      @(negedge clk);
      a_if.avalid = 1'b0;
      if (rnd && $urandom_range(0, 1) == 0) begin
        d_if.valid = 1'b0;
      end else begin
        d_if.valid = 1'b1;
        for (int j = 0; j < 4; j++) d_if.data[32*j +: 32] = pay(tag, 4*i + j);
        d_if.last = early ? (i == v.in_beats - 2) : (i == v.in_beats - 1);
      end
      #2;
      if (d_if.valid && d_if.ready) i++;
    end
    check("in_beats_taken", i, v.in_beats);
    @(negedge clk);
    a_if.avalid = 1'b0;
    d_if.valid  = 1'b0;
  endtask

  task automatic mon_tlp(input vec_t v, input int tag, input bit rnd);
    int           b = 0;
    bit           stalled = 1'b0;
    logic [133:0] saved = '0;
    logic [127:0] exp_d, mask;
    logic [3:0]   exp_k;
    bit           exp_eop;
    for (int c = 0; c < 6000 && b < v.out_beats; c++) begin
      @(negedge clk);
      tlp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled) check("stall_stable", {tlp_valid, tlp_sop, tlp_eop, tlp_keep, tlp_data}, {1'b1, saved[133:0]});
      stalled = 1'b0;
      if (tlp_valid) begin
        if (tlp_ready) begin
          exp_eop = (b == v.out_beats - 1);
          exp_k   = exp_eop ? v.eop_keep : 4'hF;
          for (int j = 0; j < 4; j++) begin
            exp_d[32*j +: 32] = exp_dw(v, tag, 4*b + j);
            mask[32*j +: 32]  = {32{exp_k[j]}};
          end
          check("beat_ctl", {tlp_sop, tlp_eop, tlp_keep}, {(b == 0), exp_eop, exp_k});
          check("beat_data", tlp_data & mask, exp_d & mask);
          b++;
        end else begin
          saved   = {tlp_sop, tlp_eop, tlp_keep, tlp_data};
          stalled = 1'b1;
        end
      end
    end
    check("out_beats", b, v.out_beats);
  endtask

  task automatic run_tlp(input int idx, input int tag, input bit rnd, input bit early);
    fork
      drive_tlp(vecs[idx], tag, rnd, early);
      mon_tlp(vecs[idx], tag, rnd);
    join
  endtask

  initial begin
    int   e0;
    bit   saw;
    vec_t z;

    vecs[0] = '{64'h1000,        13'd16,   3, {32'h0, 32'h00001000, 32'h000000FF, 32'h40000004},   2,   1, 4'b0111};
    vecs[1] = '{64'h1_00000FFE,  13'd4,    4, {32'h00000FFC, 32'h1, 32'h0000003C, 32'h60000002},   2,   1, 4'b0011};
    vecs[2] = '{64'h1001,        13'd2,    3, {32'h0, 32'h00001000, 32'h00000006, 32'h40000001},   1,   1, 4'b1111};
    vecs[3] = '{64'h2000,        13'd4096, 3, {32'h0, 32'h00002000, 32'h000000FF, 32'h40000000}, 257, 256, 4'b0111};
    vecs[4] = '{64'h3000,        13'd20,   3, {32'h0, 32'h00003000, 32'h000000FF, 32'h40000005},   2,   2, 4'b1111};
    vecs[5] = '{64'h2_00000004,  13'd32,   4, {32'h4, 32'h2, 32'h000000FF, 32'h60000008},          3,   2, 4'b1111};
    vecs[6] = '{64'h4003,        13'd6,    3, {32'h0, 32'h00004000, 32'h00000018, 32'h40000003},   2,   1, 4'b0011};

    rst         = 1'b0;
    tlp_ready   = 1'b0;
    a_if.avalid = 1'b0;
    a_if.addr   = '0;
    a_if.len    = '0;
    d_if.valid  = 1'b0;
    d_if.data   = '0;
    d_if.last   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tlp_valid", tlp_valid, 1'b0);
    check("rst_aready", a_if.aready, 1'b0);
    check("rst_dready", d_if.ready, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_aready", a_if.aready, 1'b1);

    // Full throughput, then random stalls on both sides
    for (int i = 0; i < 7; i++) run_tlp(i, i + 1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) run_tlp(i, i + 16, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("no_err_normal", err_pulses, 0);

    // A zero-length descriptor pulses err and produces no TLP
    e0 = err_pulses;
    z = vecs[0];
    z.len = '0;
    z.in_beats = 0;
    tlp_ready = 1'b1;
    drive_tlp(z, 99, 1'b0, 1'b0);
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (tlp_valid) saw = 1'b1;
    end
    check("len0_no_tlp", saw, 1'b0);
    check("len0_err", err_pulses - e0, 1);

    // last arrives one beat early: one err pulse, and the TLP keeps its full length
    e0 = err_pulses;
    run_tlp(4, 40, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("early_last_err", err_pulses - e0, 1);

    // Reset in the middle of a long TLP
    tlp_ready = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      a_if.avalid = 1'b1;
      a_if.addr   = 64'h2000;
      a_if.len    = 13'd4096;
      #2;
      if (a_if.aready) begin saw = 1'b1; break; end
    end
    check("rst_mid_accept", saw, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_if.avalid = 1'b0;
      d_if.valid  = 1'b1;
      d_if.last   = 1'b0;
    end
    #1;
    check("mid_tlp_valid", tlp_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_tlp_valid", tlp_valid, 1'b0);
    check("mid_rst_dready", d_if.ready, 1'b0);
    check("mid_rst_aready", a_if.aready, 1'b0);
    d_if.valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_idle", a_if.aready, 1'b1);
    run_tlp(0, 50, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
